// File: rtl/vga_rgb_fetch.sv
// Display-side reader of the packed RGB frame in SRAM: 3 words -> 2 pixels -> pixel FIFO -> VGA colour registers.
// Optional feature: define VGA_FETCH_UFCNT_EN to add the saturating underflow_count output.
module vga_rgb_fetch #(
  parameter logic [17:0] RGB_BASE     = 18'd146944,
  parameter int          IMAGE_PIXELS = 76800,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        Clock_50,
  input  logic        Resetn,
  input  logic        start,
  input  logic        pixel_req,
  input  logic [15:0] SRAM_read_data,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  output logic [9:0]  VGA_red,
  output logic [9:0]  VGA_green,
  output logic [9:0]  VGA_blue,
  output logic        busy,
  output logic        frame_done,
  output logic        underflow
`ifdef VGA_FETCH_UFCNT_EN
  ,
  output logic [15:0] underflow_count
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = $clog2(IMAGE_PIXELS + 1);
  localparam logic [17:0]   LAST_ADDR  = RGB_BASE + 18'(3 * IMAGE_PIXELS / 2 - 1);
  localparam logic [CW:0]   CREDIT_MAX = (CW + 1)'(FIFO_DEPTH - 2);
  localparam logic [NW-1:0] LAST_PIX   = NW'(IMAGE_PIXELS - 1);

  typedef enum logic [2:0] {
    S_FR_IDLE  = 3'd0,
    S_FR_CHECK = 3'd1,
    S_FR_W0    = 3'd2,
    S_FR_W1    = 3'd3,
    S_FR_W2    = 3'd4
  } fr_state_t;

  fr_state_t     state;
  logic [17:0]   next_word;
  logic [CW-1:0] pending;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [23:0]   fifo_mem [FIFO_DEPTH];
  logic          v1;
  logic          v2;
  logic [1:0]    phase;
  logic [15:0]   hold;
  logic [NW-1:0] pushed;

  logic          issue;
  logic          data_valid;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [23:0]   push_pix;
  logic [23:0]   head;
  logic [CW:0]   credit_sum;
  logic          credit_ok;

  assign SRAM_we_n  = 1'b1;
  assign issue      = (state == S_FR_W0) || (state == S_FR_W1) || (state == S_FR_W2);
  assign data_valid = v2 && !start;
  assign push       = data_valid && (phase != 2'd0);
  assign fifo_empty = (fifo_count == '0);
  assign pop        = pixel_req && !start && !fifo_empty;
  assign push_pix   = (phase == 2'd1) ? {hold, SRAM_read_data[15:8]} : {hold[7:0], SRAM_read_data};
  assign head       = fifo_mem[rd_ptr];
  // pending counts pixels already requested but not yet pushed, so the credit covers in-flight reads
  assign credit_sum = {1'b0, fifo_count} + {1'b0, pending};
  assign credit_ok  = (credit_sum <= CREDIT_MAX);

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state        <= S_FR_IDLE;
      SRAM_address <= '0;
      next_word    <= '0;
      pending      <= '0;
    end else if (start) begin
      state        <= S_FR_CHECK;
      SRAM_address <= RGB_BASE;
      next_word    <= RGB_BASE;
      pending      <= '0;
    end else begin
      pending <= pending + ((state == S_FR_W0) ? CW'(2) : CW'(0)) - CW'(push);
      case (state)
        S_FR_IDLE: state <= S_FR_IDLE;
        S_FR_CHECK: begin
          if (credit_ok) begin
            state        <= S_FR_W0;
            SRAM_address <= next_word;
          end
        end
        S_FR_W0: begin
          SRAM_address <= SRAM_address + 18'd1;
          state        <= S_FR_W1;
        end
        S_FR_W1: begin
          SRAM_address <= SRAM_address + 18'd1;
          state        <= S_FR_W2;
        end
        S_FR_W2: begin
          next_word <= SRAM_address + 18'd1;
          state     <= (SRAM_address == LAST_ADDR) ? S_FR_IDLE : S_FR_CHECK;
        end
        default: state <= S_FR_IDLE;
      endcase
    end
  end

  // Read data arrives two cycles after its address; phase tracks which word of the triple it is
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      phase      <= 2'd0;
      hold       <= '0;
      pushed     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      v1         <= issue && !start;
      v2         <= v1 && !start;
      frame_done <= 1'b0;
      if (start) begin
        phase  <= 2'd0;
        pushed <= '0;
        busy   <= 1'b1;
      end else begin
        if (data_valid) begin
          hold  <= SRAM_read_data;
          phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
        end
        if (push) begin
          pushed <= pushed + NW'(1);
          if (pushed == LAST_PIX) begin
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge Clock_50) begin
    if (push) fifo_mem[wr_ptr] <= push_pix;
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      VGA_red    <= '0;
      VGA_green  <= '0;
      VGA_blue   <= '0;
      underflow  <= 1'b0;
`ifdef VGA_FETCH_UFCNT_EN
      underflow_count <= '0;
`endif
    end else if (start) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      underflow  <= 1'b0;
`ifdef VGA_FETCH_UFCNT_EN
      underflow_count <= '0;
`endif
      if (pixel_req) begin
        VGA_red   <= '0;
        VGA_green <= '0;
        VGA_blue  <= '0;
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (pixel_req) begin
        if (fifo_empty) begin
          VGA_red   <= '0;
          VGA_green <= '0;
          VGA_blue  <= '0;
          underflow <= 1'b1;
`ifdef VGA_FETCH_UFCNT_EN
          if (underflow_count != 16'hFFFF) underflow_count <= underflow_count + 16'd1;
`endif
        end else begin
          VGA_red   <= {head[23:16], 2'b00};
          VGA_green <= {head[15:8], 2'b00};
          VGA_blue  <= {head[7:0], 2'b00};
        end
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge Clock_50) begin
    if (Resetn && push && !pop) assert (fifo_count != CW'(FIFO_DEPTH));
  end
`endif

endmodule

// File: tb/tb_vga_rgb_fetch.sv
// Directed self-checking bench for vga_rgb_fetch with a 2-cycle-latency SRAM read model.
// Uses a reduced frame size so the full-frame scenario stays short.
module tb_vga_rgb_fetch;

  localparam logic [17:0] BASE   = 18'd146944;
  localparam int          PIXELS = 4800;

  logic        Clock_50 = 1'b0;
  logic        Resetn;
  logic        start;
  logic        pixel_req;
  logic [15:0] SRAM_read_data;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [9:0]  VGA_red;
  logic [9:0]  VGA_green;
  logic [9:0]  VGA_blue;
  logic        busy;
  logic        frame_done;
  logic        underflow;
`ifdef VGA_FETCH_UFCNT_EN
  logic [15:0] underflow_count;
`endif

  int checks = 0;
  int errors = 0;
  int bad_pix = 0;
  int fd_count = 0;
  logic [17:0] addr_d1 = '0;
  logic [17:0] addr_d2 = '0;

  vga_rgb_fetch #(.RGB_BASE(BASE), .IMAGE_PIXELS(PIXELS), .FIFO_DEPTH(8)) dut (
    .Clock_50       (Clock_50),
    .Resetn         (Resetn),
    .start          (start),
    .pixel_req      (pixel_req),
    .SRAM_read_data (SRAM_read_data),
    .SRAM_address   (SRAM_address),
    .SRAM_we_n      (SRAM_we_n),
    .VGA_red        (VGA_red),
    .VGA_green      (VGA_green),
    .VGA_blue       (VGA_blue),
    .busy           (busy),
    .frame_done     (frame_done),
    .underflow      (underflow)
`ifdef VGA_FETCH_UFCNT_EN
    ,
    .underflow_count(underflow_count)
`endif
  );

  always #10 Clock_50 = ~Clock_50;

  // Image content: the first triple is fixed, the rest is a hash of the word offset
  function automatic logic [15:0] word_at(input logic [17:0] k);
    logic [31:0] h;
    case (k)
      18'd0:   return 16'h1122;
      18'd1:   return 16'h3344;
      18'd2:   return 16'h5566;
      default: begin
        h = 32'(k) * 32'd40503 + 32'd7;
        return h[15:0];
      end
    endcase
  endfunction

  function automatic logic [23:0] pix(input int p);
    int t;
    logic [15:0] w0, w1, w2;
    t  = p / 2;
    w0 = word_at(18'(3 * t));
    w1 = word_at(18'(3 * t + 1));
    w2 = word_at(18'(3 * t + 2));
    if (p % 2 == 0) return {w0, w1[15:8]};
    return {w1[7:0], w2};
  endfunction

  function automatic logic [29:0] expVga(input int p);
    logic [23:0] x;
    x = pix(p);
    return {x[23:16], 2'b00, x[15:8], 2'b00, x[7:0], 2'b00};
  endfunction

  always @(posedge Clock_50) begin
    addr_d1 <= SRAM_address;
    addr_d2 <= addr_d1;
  end
  assign SRAM_read_data = word_at(addr_d2 - BASE);

  always @(negedge Clock_50) begin
    if (frame_done === 1'b1) fd_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock_50);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r);
    start     = s;
    pixel_req = r;
    @(posedge Clock_50);
    #1;
    start     = 1'b0;
    pixel_req = 1'b0;
  endtask

  task automatic popCompare(input int p);
    applyStimulus(1'b0, 1'b1);
    if ({VGA_red, VGA_green, VGA_blue} !== expVga(p)) bad_pix++;
    tick(1);
  endtask

  initial begin
    Resetn    = 1'b0;
    start     = 1'b0;
    pixel_req = 1'b0;
    tick(3);
    checkOutput("rst_addr", 32'(SRAM_address), 32'd0);
    checkOutput("rst_we_n", 32'(SRAM_we_n), 32'd1);
    checkOutput("rst_vga", 32'({VGA_red, VGA_green, VGA_blue}), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_underflow", 32'(underflow), 32'd0);
    Resetn = 1'b1;
    tick(1);

    $display("[TB] underflow right after reset");
    applyStimulus(1'b0, 1'b1);
    checkOutput("t4_vga", 32'({VGA_red, VGA_green, VGA_blue}), 32'd0);
    checkOutput("t4_underflow", 32'(underflow), 32'd1);
`ifdef VGA_FETCH_UFCNT_EN
    checkOutput("t4_ufcnt", 32'(underflow_count), 32'd1);
`endif

    $display("[TB] unpack first triple");
    applyStimulus(1'b1, 1'b0);
    checkOutput("t2_addr_after_start", 32'(SRAM_address), 32'(BASE));
    checkOutput("t2_underflow_cleared", 32'(underflow), 32'd0);
    checkOutput("t2_busy", 32'(busy), 32'd1);
    tick(10);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t2_pix0", 32'({VGA_red, VGA_green, VGA_blue}), 32'({10'h044, 10'h088, 10'h0CC}));
    tick(1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t2_pix1", 32'({VGA_red, VGA_green, VGA_blue}), 32'({10'h110, 10'h154, 10'h198}));
    tick(3);
    checkOutput("t2_hold", 32'({VGA_red, VGA_green, VGA_blue}), 32'({10'h110, 10'h154, 10'h198}));

    $display("[TB] backpressure with no pops");
    applyStimulus(1'b1, 1'b0);
    tick(60);
    checkOutput("t3_last_addr", 32'(SRAM_address), 32'(BASE) + 32'd11);
    checkOutput("t3_fifo_count", 32'(dut.fifo_count), 32'd8);
    checkOutput("t3_state_check", 32'(dut.state), 32'd1);
    checkOutput("t3_busy", 32'(busy), 32'd1);
    bad_pix = 0;
    for (int p = 0; p < 1000; p++) popCompare(p);
    checkOutput("t3_pixels_0_999", 32'(bad_pix), 32'd0);
    checkOutput("t3_no_underflow", 32'(underflow), 32'd0);
    checkOutput("t3_no_frame_done", 32'(fd_count), 32'd0);

    $display("[TB] restart at pixel 1000 with simultaneous pop");
    applyStimulus(1'b1, 1'b1);
    fd_count = 0;
    checkOutput("t6_vga_zero", 32'({VGA_red, VGA_green, VGA_blue}), 32'd0);
    checkOutput("t6_no_underflow", 32'(underflow), 32'd0);
    checkOutput("t6_addr_base", 32'(SRAM_address), 32'(BASE));
    tick(20);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t6_first_pop", 32'({VGA_red, VGA_green, VGA_blue}), 32'(expVga(0)));
    tick(1);

    $display("[TB] full frame");
    bad_pix = 0;
    for (int p = 1; p < PIXELS; p++) popCompare(p);
    tick(5);
    checkOutput("t5_pixels", 32'(bad_pix), 32'd0);
    checkOutput("t5_no_underflow", 32'(underflow), 32'd0);
    checkOutput("t5_frame_done_once", 32'(fd_count), 32'd1);
    checkOutput("t5_busy_low", 32'(busy), 32'd0);
    checkOutput("t5_last_addr", 32'(SRAM_address), 32'(BASE) + 32'(3 * PIXELS / 2 - 1));
    checkOutput("t5_state_idle", 32'(dut.state), 32'd0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t5_pop_past_end_vga", 32'({VGA_red, VGA_green, VGA_blue}), 32'd0);
    checkOutput("t5_pop_past_end_underflow", 32'(underflow), 32'd1);

    $display("[TB] async reset mid-fetch");
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t1_pre_underflow", 32'(underflow), 32'd1);
    tick(8);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t1_pre_pix0", 32'({VGA_red, VGA_green, VGA_blue}), 32'(expVga(0)));
    checkOutput("t1_pre_busy", 32'(busy), 32'd1);
    #5;
    Resetn = 1'b0;
    #1;
    checkOutput("t1_addr", 32'(SRAM_address), 32'd0);
    checkOutput("t1_vga", 32'({VGA_red, VGA_green, VGA_blue}), 32'd0);
    checkOutput("t1_busy", 32'(busy), 32'd0);
    checkOutput("t1_underflow", 32'(underflow), 32'd0);
    checkOutput("t1_frame_done", 32'(frame_done), 32'd0);
    checkOutput("t1_state_idle", 32'(dut.state), 32'd0);
    checkOutput("t1_fifo_empty", 32'(dut.fifo_count), 32'd0);
    tick(2);
    checkOutput("t1_addr_held_in_reset", 32'(SRAM_address), 32'd0);
    Resetn = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
